// File: rtl/elevator_dispatcher.sv
// Two-car hall-call dispatcher: latches buttons, round-robin picks a floor, offers it to the nearest eligible car.
// Latency: button at edge k -> pending at k, SELECT at k+1, target_valid from k+2.
// Backpressure: an offer is held until target_ack or ACK_TIMEOUT cycles, then withdrawn and retried.
module elevator_dispatcher #(
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] buttons,
    input  logic [2:0] car_floor0,
    input  logic [2:0] car_floor1,
    input  logic [1:0] car_idle,
    input  logic [1:0] target_ack,
    input  logic [1:0] done,
    output logic [1:0] target_valid,
    output logic [2:0] target_floor0,
    output logic [2:0] target_floor1,
    output logic [4:0] pending
);

    typedef enum logic [1:0] {IDLE, SELECT, OFFER} state_t;

    localparam logic [3:0] TMO_LAST = 4'(ACK_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [4:0] assigned, assigned_nxt;
    logic [1:0] has_target, has_target_nxt;
    logic [2:0] car_target0, car_target1;
    logic [2:0] rr_ptr;
    logic       prio;
    logic [2:0] off_floor;
    logic       off_car;
    logic [3:0] tmo_cnt;

    logic [4:0] served, dispatchable;
    logic [1:0] eligible;
    logic [3:0] probe;
    logic       found;
    logic [2:0] sel_floor, dist0, dist1;
    logic       sel_car;
    logic       ack_hit, timeout_hit;

    assign dispatchable = pending & ~assigned;
    assign eligible[0]  = car_idle[0] & ~has_target[0] & (car_floor0 <= 3'd4);
    assign eligible[1]  = car_idle[1] & ~has_target[1] & (car_floor1 <= 3'd4);

    always_comb begin
        served = '0;
        if (done[0] && has_target[0]) served[car_target0] = 1'b1;
        if (done[1] && has_target[1]) served[car_target1] = 1'b1;
    end

    // Round-robin search starts one floor past the last accepted target.
    always_comb begin
        found     = 1'b0;
        sel_floor = '0;
        probe     = '0;
        for (int i = 1; i <= 5; i++) begin
            probe = {1'b0, rr_ptr} + 4'(i);
            if (probe > 4'd4) probe = probe - 4'd5;
            if (!found && dispatchable[probe[2:0]]) begin
                found     = 1'b1;
                sel_floor = probe[2:0];
            end
        end
    end

    always_comb begin
        dist0 = (car_floor0 > sel_floor) ? car_floor0 - sel_floor : sel_floor - car_floor0;
        dist1 = (car_floor1 > sel_floor) ? car_floor1 - sel_floor : sel_floor - car_floor1;
        if (eligible == 2'b11) begin
            if (dist0 < dist1)      sel_car = 1'b0;
            else if (dist1 < dist0) sel_car = 1'b1;
            else                    sel_car = prio;
        end else begin
            sel_car = ~eligible[0];
        end
    end

    assign ack_hit     = (state == OFFER) && target_ack[off_car];
    assign timeout_hit = (state == OFFER) && !ack_hit && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|dispatchable && |eligible) state_nxt = SELECT;
            SELECT:  state_nxt = (found && |eligible) ? OFFER : IDLE;
            OFFER:   if (ack_hit || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        assigned_nxt   = assigned & ~served;
        has_target_nxt = has_target & ~done;
        if (ack_hit) begin
            assigned_nxt[off_floor] = 1'b1;
            has_target_nxt[off_car] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pending     <= '0;
            assigned    <= '0;
            has_target  <= '0;
            car_target0 <= '0;
            car_target1 <= '0;
            rr_ptr      <= 3'd4;
            prio        <= 1'b0;
            off_floor   <= '0;
            off_car     <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            pending    <= (pending & ~served) | buttons;
            assigned   <= assigned_nxt;
            has_target <= has_target_nxt;
            if (state == SELECT) begin
                off_floor <= sel_floor;
                off_car   <= sel_car;
                tmo_cnt   <= '0;
            end else if (state == OFFER) begin
                tmo_cnt <= tmo_cnt + 4'd1;
            end
            if (ack_hit) begin
                if (off_car) car_target1 <= off_floor;
                else         car_target0 <= off_floor;
                rr_ptr <= off_floor;
                prio   <= ~off_car;
            end else if (timeout_hit) begin
                prio <= ~off_car;
            end
        end
    end

    assign target_valid  = (state == OFFER) ? (off_car ? 2'b10 : 2'b01) : 2'b00;
    assign target_floor0 = (state == OFFER && !off_car) ? off_floor : 3'd0;
    assign target_floor1 = (state == OFFER &&  off_car) ? off_floor : 3'd0;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed bench for elevator_dispatcher with a per-cycle behavioural reference model.
module tb_elevator_dispatcher;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] buttons = '0;
    logic [2:0] car_floor0 = '0, car_floor1 = '0;
    logic [1:0] car_idle = '0, target_ack = '0, done = '0;
    logic [1:0] target_valid;
    logic [2:0] target_floor0, target_floor1;
    logic [4:0] pending;

    int n_checks = 0;
    int n_errors = 0;
    bit run = 1'b0;

    elevator_dispatcher #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .buttons(buttons),
        .car_floor0(car_floor0), .car_floor1(car_floor1),
        .car_idle(car_idle), .target_ack(target_ack), .done(done),
        .target_valid(target_valid), .target_floor0(target_floor0),
        .target_floor1(target_floor1), .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model: hall calls, floor ownership per car, and the offer timeline.
    int m_pend[5];
    int m_own[5];    // -1 = unowned, else owning car
    int m_tgt[2];    // -1 = no target
    int m_phase;     // 0 waiting, 1 choosing, 2 offering
    int m_car, m_floor, m_age, m_rr, m_prio;

    task automatic model_clear();
        for (int f = 0; f < 5; f++) begin m_pend[f] = 0; m_own[f] = -1; end
        m_tgt[0] = -1; m_tgt[1] = -1;
        m_phase = 0; m_car = 0; m_floor = 0; m_age = 0; m_rr = 4; m_prio = 0;
    endtask

    function automatic int absdiff(int a, int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_step();
        int el[2];
        int any_disp, nf, acc, srv[5], d0, d1;
        el[0] = (car_idle[0] && m_tgt[0] < 0 && car_floor0 <= 4) ? 1 : 0;
        el[1] = (car_idle[1] && m_tgt[1] < 0 && car_floor1 <= 4) ? 1 : 0;
        any_disp = 0;
        for (int f = 0; f < 5; f++) begin
            srv[f] = 0;
            if (m_pend[f] != 0 && m_own[f] < 0) any_disp = 1;
        end
        acc = -1;
        case (m_phase)
            0: if (any_disp != 0 && (el[0] + el[1]) > 0) m_phase = 1;
            1: begin
                nf = -1;
                for (int k = 1; k <= 5; k++)
                    if (nf < 0 && m_pend[(m_rr + k) % 5] != 0 && m_own[(m_rr + k) % 5] < 0)
                        nf = (m_rr + k) % 5;
                if (nf >= 0 && (el[0] + el[1]) > 0) begin
                    d0 = absdiff(int'(car_floor0), nf);
                    d1 = absdiff(int'(car_floor1), nf);
                    if (el[0] != 0 && el[1] != 0) m_car = (d0 < d1) ? 0 : (d1 < d0) ? 1 : m_prio;
                    else                          m_car = (el[0] != 0) ? 0 : 1;
                    m_floor = nf; m_age = 0; m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end
            default: begin
                if (target_ack[m_car]) begin
                    acc = m_car; m_phase = 0;
                end else begin
                    m_age++;
                    if (m_age == TMO) begin m_prio = 1 - m_car; m_phase = 0; end
                end
            end
        endcase
        for (int c = 0; c < 2; c++)
            if (done[c] && m_tgt[c] >= 0) begin
                srv[m_tgt[c]] = 1; m_own[m_tgt[c]] = -1; m_tgt[c] = -1;
            end
        if (acc >= 0) begin
            m_own[m_floor] = acc; m_tgt[acc] = m_floor; m_rr = m_floor; m_prio = 1 - acc;
        end
        for (int f = 0; f < 5; f++)
            m_pend[f] = ((m_pend[f] != 0 && srv[f] == 0) || buttons[f]) ? 1 : 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_clear();
        else        model_step();
    end

    always @(negedge clk) begin
        logic [4:0] ep;
        logic [1:0] ev;
        logic [2:0] ef0, ef1;
        if (run) begin
            for (int f = 0; f < 5; f++) ep[f] = (m_pend[f] != 0);
            ev  = (m_phase == 2) ? ((m_car == 1) ? 2'b10 : 2'b01) : 2'b00;
            ef0 = (m_phase == 2 && m_car == 0) ? 3'(m_floor) : 3'd0;
            ef1 = (m_phase == 2 && m_car == 1) ? 3'(m_floor) : 3'd0;
            n_checks++;
            if (pending !== ep || target_valid !== ev || target_floor0 !== ef0 || target_floor1 !== ef1) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t pend/valid/f0/f1 got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         $time, pending, target_valid, target_floor0, target_floor1, ep, ev, ef0, ef1);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        model_clear();
        repeat (3) cyc();
        run = 1'b1;
        chk("rst_valid", 8'(target_valid), 8'h0);
        chk("rst_pend", 8'(pending), 8'h0);
        chk("rst_f0", 8'(target_floor0), 8'h0);
        chk("rst_f1", 8'(target_floor1), 8'h0);
        reset = 1'b1;
        cyc();

        // Simultaneous calls at floors 0 and 4.
        car_floor0 = 3'd1; car_floor1 = 3'd3; car_idle = 2'b11;
        buttons = 5'b10001; cyc(); buttons = '0;
        chk("sim_pend", 8'(pending), 8'h11);
        cyc(); cyc();
        chk("sim_first_valid", 8'(target_valid), 8'h1);
        chk("sim_first_floor", 8'(target_floor0), 8'h0);
        target_ack = 2'b01; cyc(); target_ack = '0;
        chk("sim_ack_drop", 8'(target_valid), 8'h0);
        cyc(); cyc();
        chk("sim_second_valid", 8'(target_valid), 8'h2);
        chk("sim_second_floor", 8'(target_floor1), 8'h4);
        target_ack = 2'b10; cyc(); target_ack = '0;
        done = 2'b11; cyc(); done = '0;
        chk("sim_cleared", 8'(pending), 8'h0);

        // Nearest car wins floor 3; pending held until served.
        car_floor0 = 3'd0; car_floor1 = 3'd4;
        buttons = 5'b01000; cyc(); buttons = '0;
        cyc();
        chk("near_select_quiet", 8'(target_valid), 8'h0);
        cyc();
        chk("near_valid", 8'(target_valid), 8'h2);
        chk("near_floor", 8'(target_floor1), 8'h3);
        target_ack = 2'b10; cyc(); target_ack = '0;
        cyc(); cyc();
        chk("near_hold_pend", 8'(pending), 8'h08);
        chk("near_hold_valid", 8'(target_valid), 8'h0);
        done = 2'b10; cyc(); done = '0;
        chk("near_served", 8'(pending), 8'h0);

        // Tie alternates between cars; stray ack ignored.
        car_floor0 = 3'd2; car_floor1 = 3'd2;
        buttons = 5'b00100; cyc(); buttons = '0; cyc(); cyc();
        chk("tie1_valid", 8'(target_valid), 8'h1);
        chk("tie1_floor", 8'(target_floor0), 8'h2);
        target_ack = 2'b01; cyc(); target_ack = '0;
        done = 2'b01; cyc(); done = '0;
        buttons = 5'b00100; cyc(); buttons = '0; cyc(); cyc();
        chk("tie2_valid", 8'(target_valid), 8'h2);
        chk("tie2_floor", 8'(target_floor1), 8'h2);
        target_ack = 2'b01; cyc(); target_ack = '0;
        chk("stray_ack", 8'(target_valid), 8'h2);
        target_ack = 2'b10; cyc(); target_ack = '0;
        done = 2'b10; cyc(); done = '0;

        // Timeout: car1 at an invalid floor, only car0 eligible.
        car_floor0 = 3'd0; car_floor1 = 3'd7;
        buttons = 5'b00010; cyc(); buttons = '0; cyc(); cyc();
        begin
            int hi = 0;
            for (int i = 0; i < 30 && target_valid == 2'b01; i++) begin hi++; cyc(); end
            chk("tmo_len", 8'(hi), 8'(TMO));
        end
        chk("tmo_pend", 8'(pending), 8'h02);
        cyc();
        chk("tmo_gap", 8'(target_valid), 8'h0);
        cyc();
        chk("tmo_reoffer", 8'(target_valid), 8'h1);
        chk("tmo_reoffer_floor", 8'(target_floor0), 8'h1);
        target_ack = 2'b01; cyc(); target_ack = '0;
        done = 2'b01; cyc(); done = '0;

        // Done and button on the same floor in one cycle.
        car_idle = 2'b01;
        buttons = 5'b00010; cyc(); buttons = '0; cyc(); cyc();
        target_ack = 2'b01; cyc(); target_ack = '0;
        cyc();
        done = 2'b01; buttons = 5'b00010; cyc(); done = '0; buttons = '0;
        chk("collide_pend", 8'(pending), 8'h02);
        cyc(); cyc();
        chk("collide_redispatch", 8'(target_valid), 8'h1);
        chk("collide_floor", 8'(target_floor0), 8'h1);
        car_idle = 2'b00; cyc();
        chk("idle_drop_keeps", 8'(target_valid), 8'h1);

        // Asynchronous reset mid-offer.
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 8'(target_valid), 8'h0);
        chk("arst_pend", 8'(pending), 8'h0);
        buttons = 5'b00100; cyc();
        chk("arst_btn_ignored", 8'(pending), 8'h0);
        buttons = '0; reset = 1'b1; car_idle = 2'b01;
        repeat (5) cyc();
        chk("post_rst_quiet", 8'(target_valid), 8'h0);
        buttons = 5'b00001; cyc(); buttons = '0; cyc(); cyc();
        chk("post_rst_offer", 8'(target_valid), 8'h1);
        chk("post_rst_floor", 8'(target_floor0), 8'h0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/elevator_dispatcher.md
ELEVATOR_DISPATCHER -- requirements
Module: elevator_dispatcher

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 8, max cycles an offer is held without acknowledge (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 buttons  input  5  hall-call buttons, bit i = floor i; level, sampled every edge.
REQ-005 car_floor0 / car_floor1  input  3 each  current floor of car 0 / car 1; values >4 invalid.
REQ-006 car_idle  input  2  bit c = car c stopped, door closed, able to accept a target.
REQ-007 target_ack  input  2  bit c = car c accepts its offered target this cycle.
REQ-008 done  input  2  bit c = one-cycle pulse, car c has served its assigned target.
REQ-009 target_valid  output  2  bit c = target offered to car c; at most one bit set.
REQ-010 target_floor0 / target_floor1  output  3 each  offered floor, stable while target_valid[c]=1.
REQ-011 pending  output  5  registered outstanding hall calls.

Function
REQ-012 pending <= (pending & ~served) | buttons each edge; served = floor of a done pulse; button wins when both hit the same floor in one cycle (bit stays set, becomes unassigned).
REQ-013 Per car: has_target bit and car_target[2:0]; car c eligible when car_idle[c]=1, has_target[c]=0, car_floorc<=4.
REQ-014 assigned[4:0] marks floors owned by a car; a floor is dispatchable when pending=1 and assigned=0.
REQ-015 FSM states IDLE, SELECT, OFFER; reset state IDLE.
REQ-016 IDLE -> SELECT when at least one floor dispatchable and at least one car eligible; else stay.
REQ-017 SELECT (1 cycle): floor f = first dispatchable floor searching upward from rr_ptr+1, wrapping 4->0; registers f.
REQ-018 SELECT car choice: eligible car with smallest |car_floor - f| (3-bit unsigned); tie or both-equal -> car named by prio bit; single eligible car -> that car; -> OFFER.
REQ-019 OFFER: target_valid[c]=1, target_floorc=f; timeout counter increments each OFFER cycle from 0.
REQ-020 target_ack[c]=1 in OFFER -> assigned[f]=1, has_target[c]=1, car_target[c]=f, rr_ptr=f, prio=other car, target_valid drops next edge, -> IDLE.
REQ-021 No ack after ACK_TIMEOUT OFFER cycles -> withdraw offer (target_valid 0), f stays pending/unassigned, prio=other car, -> IDLE.
REQ-022 target_ack on a bit not offered ignored; done[c] with has_target[c]=0 ignored.
REQ-023 done[c] with has_target[c]=1 -> clear pending[car_target[c]] (subject to REQ-012), assigned bit, has_target[c].
REQ-024 Latency: button sampled at edge k -> pending at k, SELECT at k+1, target_valid high after k+2.
REQ-025 car_idle dropping during OFFER does not cancel the offer; only ack, timeout or reset end it.
REQ-026 target_floorc reads 0 when target_valid[c]=0.

Reset
REQ-027 reset=0: pending, assigned, has_target, car_target, target_valid, target_floor*, timeout counter all 0; state IDLE; rr_ptr=4 (first search starts at floor 0); prio=car 0.
REQ-028 Reset mid-OFFER drops target_valid without a clock edge; buttons ignored while reset=0.

Verification
REQ-029 Car0 at 0, car1 at 4, both idle; buttons=01000 one cycle -> target_valid=10, target_floor1=3 after 2 edges; ack -> pending=01000 until done[1], then 00000.
REQ-030 Both cars at 2 idle; press floor 2 -> car0 offered; ack, done; press floor 2 again -> car1 offered (prio toggled).
REQ-031 ACK_TIMEOUT=8, car0 only eligible, no ack -> target_valid[0] high exactly 8 cycles, drops, re-offered via IDLE/SELECT.
REQ-032 buttons=10001 simultaneously, both idle -> floor 0 offered first, after ack floor 4 offered to other car.
REQ-033 done[0] for floor 1 and buttons[1]=1 same cycle -> pending[1] remains 1, floor 1 re-dispatched.
REQ-034 reset=0 asserted during OFFER -> target_valid=00, pending=00000 before next edge; after release, no offer until new button.
